zxuno_uart_master: RTL and testbench

ZXUNO_UART_MASTER -- requirements
Module: zxuno_uart_master

---
 rtl/zxuno_uart_pkg.sv | 30 +++
 rtl/zxuno_uart_fifo.sv | 57 +++++
 rtl/zxuno_uart_master.sv | 155 +++++++++++++++
 tb/tb_zxuno_uart_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zxuno_uart_pkg.sv
// Shared definitions for the ZX-Uno UART register block and its bus master:
// register addresses, status bit positions, FSM state encoding and FIFO geometry.
package zxuno_uart_pkg;

    localparam logic [7:0] UartDataAddr = 8'hC6;
    localparam logic [7:0] UartStatAddr = 8'hC7;

    localparam int unsigned StatRxPendingBit = 7;
    localparam int unsigned StatTxBusyBit    = 6;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned FifoPtrW  = 2;
    localparam int unsigned FifoCntW  = 3;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStatRd  = 3'd1,
        StStatGap = 3'd2,
        StDataRd  = 3'd3,
        StDataGap = 3'd4,
        StDataWr  = 3'd5,
        StWrGap   = 3'd6
    } state_e;

    // A read with nobody driving the bus is seen as all zeros.
    function automatic logic [7:0] rd_sample(input logic [7:0] data, input logic oe_n);
        return oe_n ? 8'h00 : data;
    endfunction

endpackage

// File: rtl/zxuno_uart_fifo.sv
// Four-entry first-word-fall-through FIFO used for both the TX and RX byte queues.
module zxuno_uart_fifo
    import zxuno_uart_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_bus,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             valid,
    output logic             full
);

    logic [Width-1:0]    mem [FifoDepth];
    logic [FifoPtrW-1:0] wptr_q;
    logic [FifoPtrW-1:0] rptr_q;
    logic [FifoCntW-1:0] cnt_q;
    logic                do_push;
    logic                do_pop;

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == FifoCntW'(FifoDepth));
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk_bus) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + FifoPtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + FifoPtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + FifoCntW'(1);
                2'b01:   cnt_q <= cnt_q - FifoCntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/zxuno_uart_master.sv
// Polls the ZX-Uno UART status register and moves bytes between the UART data
// register and a pair of local TX/RX FIFOs using timed read/write strobes.
module zxuno_uart_master
    import zxuno_uart_pkg::*;
#(
    parameter logic [7:0]  UARTDATA = UartDataAddr,
    parameter logic [7:0]  UARTSTAT = UartStatAddr,
    parameter int unsigned HOLD     = 4
) (
    input  logic       clk_bus,
    input  logic       rst_n,
    output logic [7:0] zxuno_addr,
    output logic       zxuno_regrd,
    output logic       zxuno_regwr,
    output logic [7:0] dout,
    input  logic [7:0] din,
    input  logic       oe_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       bus_err
);

    localparam int unsigned PhW = $clog2(HOLD) + 1;

    state_e         state_q;
    logic [PhW-1:0] ph_q;
    logic           ph_last;
    logic           stat_rx_q;
    logic           stat_busy_q;

    logic [7:0]     rd_byte;
    logic           rd_point;
    logic           tx_full;
    logic           tx_nonempty;
    logic [7:0]     tx_head;
    logic           tx_push;
    logic           tx_pop;
    logic           rx_full;
    logic           rx_push;
    logic           rx_pop;

    assign ph_last  = (ph_q == PhW'(HOLD - 1));
    assign rd_byte  = rd_sample(din, oe_n);
    assign rd_point = ph_last & ((state_q == StStatRd) | (state_q == StDataRd));

    assign tx_ready = ~tx_full;
    assign tx_push  = tx_valid & tx_ready;
    assign tx_pop   = ph_last & (state_q == StDataWr);
    assign rx_push  = ph_last & (state_q == StDataRd);
    assign rx_pop   = rx_valid & rx_ready;

    zxuno_uart_fifo #(
        .Width (8)
    ) u_tx_fifo (
        .clk_bus (clk_bus),
        .rst_n   (rst_n),
        .push    (tx_push),
        .wdata   (tx_data),
        .pop     (tx_pop),
        .rdata   (tx_head),
        .valid   (tx_nonempty),
        .full    (tx_full)
    );

    zxuno_uart_fifo #(
        .Width (8)
    ) u_rx_fifo (
        .clk_bus (clk_bus),
        .rst_n   (rst_n),
        .push    (rx_push),
        .wdata   (rd_byte),
        .pop     (rx_pop),
        .rdata   (rx_data),
        .valid   (rx_valid),
        .full    (rx_full)
    );

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ph_q        <= '0;
            stat_rx_q   <= 1'b0;
            stat_busy_q <= 1'b0;
            zxuno_addr  <= 8'h00;
            zxuno_regrd <= 1'b0;
            zxuno_regwr <= 1'b0;
            dout        <= 8'h00;
            bus_err     <= 1'b0;
        end else begin
            if (state_q != StIdle) begin
                ph_q <= ph_last ? '0 : ph_q + PhW'(1);
            end
            if (rd_point && oe_n) begin
                bus_err <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    // Reading status clears rx-pending, so only poll with room to land the byte.
                    if (!rx_full) begin
                        state_q     <= StStatRd;
                        zxuno_addr  <= UARTSTAT;
                        zxuno_regrd <= 1'b1;
                    end
                end
                StStatRd: begin
                    if (ph_last) begin
                        stat_rx_q   <= rd_byte[StatRxPendingBit];
                        stat_busy_q <= rd_byte[StatTxBusyBit];
                        zxuno_regrd <= 1'b0;
                        state_q     <= StStatGap;
                    end
                end
                StStatGap: begin
                    if (ph_last) begin
                        if (stat_rx_q) begin
                            state_q     <= StDataRd;
                            zxuno_addr  <= UARTDATA;
                            zxuno_regrd <= 1'b1;
                        end else if (!stat_busy_q && tx_nonempty) begin
                            state_q     <= StDataWr;
                            zxuno_addr  <= UARTDATA;
                            zxuno_regwr <= 1'b1;
                            dout        <= tx_head;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDataRd: begin
                    if (ph_last) begin
                        zxuno_regrd <= 1'b0;
                        state_q     <= StDataGap;
                    end
                end
                StDataWr: begin
                    if (ph_last) begin
                        zxuno_regwr <= 1'b0;
                        state_q     <= StWrGap;
                    end
                end
                StDataGap, StWrGap: begin
                    if (ph_last) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_zxuno_uart_master.sv
// Directed bench for zxuno_uart_master with a small behavioural UART register block.
module tb_zxuno_uart_master;

    localparam int unsigned HOLD = 4;

    logic       clk_bus = 1'b0;
    logic       rst_n;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] dout;
    logic [7:0] din;
    logic       oe_n;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk_bus = ~clk_bus;

    zxuno_uart_master #(
        .UARTDATA (8'hC6),
        .UARTSTAT (8'hC7),
        .HOLD     (HOLD)
    ) dut (
        .clk_bus     (clk_bus),
        .rst_n       (rst_n),
        .zxuno_addr  (zxuno_addr),
        .zxuno_regrd (zxuno_regrd),
        .zxuno_regwr (zxuno_regwr),
        .dout        (dout),
        .din         (din),
        .oe_n        (oe_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .bus_err     (bus_err)
    );

    // Register block model: pending while injected bytes remain unread.
    logic [7:0] rx_bytes [8];
    int         rx_injected = 0;
    int         rx_consumed = 0;
    logic       tx_busy = 1'b0;
    logic       oe_bad  = 1'b0;
    logic [2:0] rd_idx;

    assign rd_idx = rx_consumed[2:0];
    assign din    = (zxuno_addr == 8'hC7) ? {(rx_injected != rx_consumed), tx_busy, 6'b0}
                                          : rx_bytes[rd_idx];
    assign oe_n   = oe_bad | ~zxuno_regrd;

    // Bus monitor
    int         rd_run = 0, wr_run = 0, rd_acc = 0, wr_cnt = 0;
    int         rd_width_bad = 0, wr_width_bad = 0, wr_unstable = 0, wr_addr_bad = 0;
    int         both_err = 0;
    logic [7:0] rd_addr, wr_data0, last_wr;

    initial begin
        forever begin
            @(negedge clk_bus);
            if (rst_n !== 1'b1) begin
                rd_run = 0;
                wr_run = 0;
            end else begin
                if (zxuno_regrd && zxuno_regwr) both_err++;
                if (zxuno_regrd) begin
                    rd_run++;
                    rd_addr = zxuno_addr;
                end else if (rd_run != 0) begin
                    if (rd_run != HOLD) rd_width_bad++;
                    rd_acc++;
                    if (rd_addr == 8'hC6) rx_consumed++;
                    rd_run = 0;
                end
                if (zxuno_regwr) begin
                    wr_run++;
                    if (zxuno_addr != 8'hC6) wr_addr_bad++;
                    if (wr_run == 1) wr_data0 = dout;
                    else if (dout != wr_data0) wr_unstable++;
                end else if (wr_run != 0) begin
                    if (wr_run != HOLD) wr_width_bad++;
                    wr_cnt++;
                    last_wr = wr_data0;
                    wr_run  = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk_bus);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk_bus);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk_bus);
        rx_ready = 1'b1;
        @(negedge clk_bus);
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_bus);
    endtask

    initial begin
        int lat;
        int snap;
        logic seen;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        idle(2);
        check("rst_regrd", zxuno_regrd, 1'b0);
        check("rst_regwr", zxuno_regwr, 1'b0);
        check("rst_addr", zxuno_addr, 8'h00);
        check("rst_dout", dout, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_bus_err", bus_err, 1'b0);
        #2 rst_n = 1'b1;

        // Idle polling with nothing to send
        idle(30);
        check("polling_active", rd_acc > 0, 1'b1);
        check("no_write_idle", wr_cnt, 0);

        // Single TX byte, status 8'h00
        push_tx(8'hA5);
        check("tx_ready_after_push", tx_ready, 1'b1);
        lat = 1;
        while (!zxuno_regwr && lat <= 4 * HOLD + 2) begin
            @(negedge clk_bus);
            lat++;
        end
        check("tx_latency_bound", zxuno_regwr, 1'b1);
        for (int i = 0; i < 60 && wr_cnt < 1; i++) @(negedge clk_bus);
        idle(2);
        check("tx_one_write", wr_cnt, 1);
        check("tx_write_data", last_wr, 8'hA5);
        check("tx_write_width", wr_width_bad, 0);
        check("tx_dout_stable", wr_unstable, 0);
        check("tx_write_addr", wr_addr_bad, 0);
        check("tx_ready_stays", tx_ready, 1'b1);

        // Status 8'h80 then data 8'h5A
        rx_bytes[0] = 8'h5A;
        rx_injected = 1;
        for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk_bus);
        idle(40);
        check("rx_valid_5a", rx_valid, 1'b1);
        check("rx_data_5a", rx_data, 8'h5A);
        check("rx_consumed_one", rx_consumed, 1);
        check("rd_width", rd_width_bad, 0);
        pop_rx();
        check("rx_single_entry", rx_valid, 1'b0);

        // TX busy holds off writes until status clears
        tx_busy = 1'b1;
        idle(4 * HOLD + 6);
        push_tx(8'h11);
        idle(60);
        check("busy_no_write", wr_cnt, 1);
        tx_busy = 1'b0;
        for (int i = 0; i < 60 && wr_cnt < 2; i++) @(negedge clk_bus);
        idle(40);
        check("busy_one_write", wr_cnt, 2);
        check("busy_write_data", last_wr, 8'h11);

        // Fill RX FIFO, polling must stop, then resume after a pop
        for (int k = 1; k <= 4; k++) rx_bytes[k] = 8'(k);
        rx_injected = 5;
        idle(200);
        check("rx_fill_consumed", rx_consumed, 5);
        check("rx_full_head", rx_data, 8'h01);
        snap = rd_acc;
        idle(40);
        check("rx_full_no_poll", rd_acc, snap);
        check("rx_full_regrd_low", zxuno_regrd, 1'b0);
        pop_rx();
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_bus);
            if (zxuno_regrd) seen = 1'b1;
        end
        check("poll_resumes", seen, 1'b1);
        check("rx_head_02", rx_data, 8'h02);
        for (int k = 3; k <= 4; k++) begin
            pop_rx();
            check("rx_drain", rx_data, 8'(k));
        end
        pop_rx();
        check("rx_drained", rx_valid, 1'b0);

        // Undriven bus during a status read
        check("bus_err_clean", bus_err, 1'b0);
        oe_bad = 1'b1;
        idle(4 * (2 * HOLD + 1) + 4);
        check("bus_err_set", bus_err, 1'b1);
        oe_bad = 1'b0;
        idle(30);
        check("bus_err_sticky", bus_err, 1'b1);

        // Reset in the middle of a write strobe
        push_tx(8'h77);
        for (int i = 0; i < 60 && !zxuno_regwr; i++) @(negedge clk_bus);
        check("mid_wr_started", zxuno_regwr, 1'b1);
        @(negedge clk_bus);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_regwr", zxuno_regwr, 1'b0);
        check("mid_rst_tx_ready", tx_ready, 1'b1);
        check("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_bus_err", bus_err, 1'b0);
        check("mid_rst_addr", zxuno_addr, 8'h00);
        @(negedge clk_bus);
        #2 rst_n = 1'b1;
        idle(60);
        check("mid_rst_discard", wr_cnt, 2);
        check("never_both_strobes", both_err, 0);
        check("rd_width_final", rd_width_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
